// File: rtl/tile_map_ctl.sv
// tile_map_ctl: 32x24 background tile map with a raster lookup aligned to the delayed timing,
// vblank-deferred tile writes and a one-cycle tile read port.
module tile_map_ctl #(
    parameter int         MAP_W     = 32,
    parameter int         MAP_H     = 24,
    parameter int         FLASH_BIT = 4,
    parameter logic [2:0] WALL_TEX  = 3'd1,
    parameter logic [2:0] FLOOR_TEX = 3'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        hblank,
    input  logic        vblank,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblank_out,
    output logic        vblank_out,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic [11:0] rgb_out,
    output logic [2:0]  texture_number,
    output logic        inversion,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [4:0]  wr_x,
    input  logic [4:0]  wr_y,
    input  logic [2:0]  wr_tex,
    input  logic        wr_flash,
    input  logic [4:0]  rd_x,
    input  logic [4:0]  rd_y,
    output logic [2:0]  rd_tex,
    output logic        rd_flash,
    output logic        init_done
);
    localparam logic [4:0]  LAST_X   = 5'(MAP_W - 1);
    localparam logic [4:0]  LAST_Y   = 5'(MAP_H - 1);
    localparam logic [9:0]  LAST_IDX = 10'(MAP_W * MAP_H - 1);
    localparam logic [10:0] H_END    = 11'(MAP_W * 32);
    localparam logic [10:0] V_END    = 11'(MAP_H * 32);

    typedef enum logic {INIT, RUN} state_t;

    state_t              state, state_next;
    logic [9:0]          sweep;
    logic [3:0]          map [0:MAP_W*MAP_H-1];
    logic                pend_valid;
    logic [4:0]          pend_x, pend_y;
    logic [2:0]          pend_tex;
    logic                pend_flash;
    logic [FLASH_BIT:0]  frame_cnt;
    logic [3:0]          init_entry, pix_entry, rd_entry;
    logic                pix_on, rd_in_range, pend_in_range, commit;

    always_comb begin
        state_next    = (state == INIT && sweep == LAST_IDX) ? RUN : state;
        init_entry    = (sweep[4:0] == 5'd0 || sweep[4:0] == LAST_X || sweep[9:5] == 5'd0 ||
                         sweep[9:5] == LAST_Y || (!sweep[0] && !sweep[5])) ? {1'b0, WALL_TEX} : {1'b0, FLOOR_TEX};
        pix_on        = state == RUN && hcount < H_END && vcount < V_END && !hblank && !vblank;
        pix_entry     = map[{vcount[9:5], hcount[9:5]}];
        rd_in_range   = rd_x <= LAST_X && rd_y <= LAST_Y;
        rd_entry      = map[{rd_y, rd_x}];
        pend_in_range = pend_x <= LAST_X && pend_y <= LAST_Y;
        commit        = state == RUN && pend_valid && vblank;
    end

    assign wr_ready  = state == RUN && !pend_valid;
    assign init_done = state == RUN;

    // Map storage has no reset; INIT rewrites every entry after each reset.
    always_ff @(posedge clk) begin
        if (state == INIT)
            map[sweep] <= init_entry;
        else if (commit && pend_in_range)
            map[{pend_y, pend_x}] <= {pend_flash, pend_tex};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= INIT;
            sweep          <= 10'd0;
            hsync_out      <= 1'b0;
            vsync_out      <= 1'b0;
            hblank_out     <= 1'b0;
            vblank_out     <= 1'b0;
            hcount_out     <= 11'd0;
            vcount_out     <= 11'd0;
            rgb_out        <= 12'd0;
            texture_number <= 3'd0;
            inversion      <= 1'b0;
            rd_tex         <= 3'd0;
            rd_flash       <= 1'b0;
            frame_cnt      <= '0;
            pend_valid     <= 1'b0;
            pend_x         <= 5'd0;
            pend_y         <= 5'd0;
            pend_tex       <= 3'd0;
            pend_flash     <= 1'b0;
        end else begin
            state          <= state_next;
            sweep          <= (state == INIT) ? sweep + 10'd1 : sweep;
            hsync_out      <= hsync;
            vsync_out      <= vsync;
            hblank_out     <= hblank;
            vblank_out     <= vblank;
            hcount_out     <= hcount;
            vcount_out     <= vcount;
            rgb_out        <= rgb;
            texture_number <= pix_on ? pix_entry[2:0] : 3'd0;
            inversion      <= pix_on && pix_entry[3] && frame_cnt[FLASH_BIT];
            rd_tex         <= (state == INIT) ? 3'd0 : rd_in_range ? rd_entry[2:0] : WALL_TEX;
            rd_flash       <= state == RUN && rd_in_range && rd_entry[3];
            // vblank_out doubles as the previous vblank sample for edge detection.
            if (vblank && !vblank_out)
                frame_cnt <= frame_cnt + 1'b1;
            if (wr_valid && wr_ready) begin
                pend_valid <= 1'b1;
                pend_x     <= wr_x;
                pend_y     <= wr_y;
                pend_tex   <= wr_tex;
                pend_flash <= wr_flash;
            end else if (commit) begin
                pend_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tile_map_ctl.sv
// tb_tile_map_ctl: directed stimulus with a per-cycle behavioural model of the tile map
// and literal spot checks that pin the model.
module tb_tile_map_ctl;
    localparam int         FB    = 1;
    localparam logic [2:0] WALL  = 3'd1;
    localparam logic [2:0] FLOOR = 3'd0;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        hsync = 1'b0, vsync = 1'b0, hblank = 1'b0, vblank = 1'b0;
    logic [10:0] hcount = 11'd0, vcount = 11'd0;
    logic [11:0] rgb = 12'd0;
    logic        wr_valid = 1'b0, wr_flash = 1'b0;
    logic [4:0]  wr_x = 5'd0, wr_y = 5'd0, rd_x = 5'd0, rd_y = 5'd0;
    logic [2:0]  wr_tex = 3'd0;
    logic        hsync_out, vsync_out, hblank_out, vblank_out, inversion, wr_ready, rd_flash, init_done;
    logic [10:0] hcount_out, vcount_out;
    logic [11:0] rgb_out;
    logic [2:0]  texture_number, rd_tex;

    tile_map_ctl #(.FLASH_BIT(FB)) dut (
        .clk(clk), .rst_n(rst_n),
        .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
        .hcount(hcount), .vcount(vcount), .rgb(rgb),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblank_out(hblank_out), .vblank_out(vblank_out),
        .hcount_out(hcount_out), .vcount_out(vcount_out), .rgb_out(rgb_out),
        .texture_number(texture_number), .inversion(inversion),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_tex(wr_tex), .wr_flash(wr_flash),
        .rd_x(rd_x), .rd_y(rd_y), .rd_tex(rd_tex), .rd_flash(rd_flash),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0]  m_map [0:767];
    int          m_cyc = 0, m_frames = 0, m_px = 0, m_py = 0;
    bit          m_prev_vb = 0, m_pend = 0, m_pflash = 0, m_valid = 0;
    logic [2:0]  m_ptex = 3'd0;
    logic        e_hs, e_vs, e_hb, e_vb, e_inv, e_rflash, e_ready, e_done;
    logic [10:0] e_hc, e_vc;
    logic [11:0] e_rgb;
    logic [2:0]  e_tex, e_rtex;

    function automatic logic [3:0] init_entry(int x, int y);
        return (x == 0 || x == 31 || y == 0 || y == 23 || (x % 2 == 0 && y % 2 == 0)) ? {1'b0, WALL} : {1'b0, FLOOR};
    endfunction

    always @(posedge clk) begin
        bit run, on;
        logic [3:0] ent;
        m_valid = 1;
        if (!rst_n) begin
            {e_hs, e_vs, e_hb, e_vb, e_inv, e_rflash} = '0;
            e_hc = '0; e_vc = '0; e_rgb = '0; e_tex = '0; e_rtex = '0;
            for (int i = 0; i < 768; i++) m_map[i] = init_entry(i % 32, i / 32);
            m_cyc = 0; m_frames = 0; m_prev_vb = 0; m_pend = 0;
        end else begin
            e_hs = hsync; e_vs = vsync; e_hb = hblank; e_vb = vblank;
            e_hc = hcount; e_vc = vcount; e_rgb = rgb;
            run = m_cyc >= 768;
            on  = run && hcount < 1024 && vcount < 768 && !hblank && !vblank;
            ent = on ? m_map[(int'(vcount) / 32) * 32 + int'(hcount) / 32] : 4'd0;
            e_tex = ent[2:0];
            e_inv = on && ent[3] && ((m_frames >> FB) & 1) == 1;
            if (!run) begin
                e_rtex = 3'd0; e_rflash = 1'b0;
            end else if (rd_x < 32 && rd_y < 24) begin
                e_rtex = m_map[int'(rd_y) * 32 + int'(rd_x)][2:0];
                e_rflash = m_map[int'(rd_y) * 32 + int'(rd_x)][3];
            end else begin
                e_rtex = WALL; e_rflash = 1'b0;
            end
            if (run && m_pend && vblank) begin
                if (m_px < 32 && m_py < 24) m_map[m_py * 32 + m_px] = {m_pflash, m_ptex};
                m_pend = 0;
            end else if (run && !m_pend && wr_valid) begin
                m_px = wr_x; m_py = wr_y; m_ptex = wr_tex; m_pflash = wr_flash; m_pend = 1;
            end
            if (vblank && !m_prev_vb) m_frames++;
            m_prev_vb = vblank;
            m_cyc++;
        end
        e_done  = rst_n && m_cyc >= 768;
        e_ready = e_done && !m_pend;
    end

    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            chk("hsync_out", 16'(hsync_out), 16'(e_hs));
            chk("vsync_out", 16'(vsync_out), 16'(e_vs));
            chk("hblank_out", 16'(hblank_out), 16'(e_hb));
            chk("vblank_out", 16'(vblank_out), 16'(e_vb));
            chk("hcount_out", 16'(hcount_out), 16'(e_hc));
            chk("vcount_out", 16'(vcount_out), 16'(e_vc));
            chk("rgb_out", 16'(rgb_out), 16'(e_rgb));
            chk("texture_number", 16'(texture_number), 16'(e_tex));
            chk("inversion", 16'(inversion), 16'(e_inv));
            chk("rd_tex", 16'(rd_tex), 16'(e_rtex));
            chk("rd_flash", 16'(rd_flash), 16'(e_rflash));
            chk("wr_ready", 16'(wr_ready), 16'(e_ready));
            chk("init_done", 16'(init_done), 16'(e_done));
        end
    end

    always @(negedge clk) begin
        rgb   = 12'($urandom);
        hsync = 1'($urandom);
        vsync = 1'($urandom);
    end

    // ---------------- directed stimulus ----------------
    task automatic rd_check(string nm, int x, int y, logic [2:0] et);
        @(negedge clk); rd_x = 5'(x); rd_y = 5'(y);
        @(posedge clk); #1; chk(nm, 16'(rd_tex), 16'(et));
    endtask

    task automatic pix_check(string nm, int h, int v, logic hb, logic [2:0] et);
        @(negedge clk); hcount = 11'(h); vcount = 11'(v); hblank = hb;
        @(posedge clk); #1;
        chk(nm, 16'(texture_number), 16'(et));
        chk({nm, "_hcount_out"}, 16'(hcount_out), 16'(h));
    endtask

    task automatic wr(int x, int y, logic [2:0] t, logic f);
        @(negedge clk);
        chk("wr_ready_before", 16'(wr_ready), 16'd1);
        wr_valid = 1'b1; wr_x = 5'(x); wr_y = 5'(y); wr_tex = t; wr_flash = f;
        @(posedge clk); #1; chk("wr_ready_after_accept", 16'(wr_ready), 16'd0);
        @(negedge clk); wr_valid = 1'b0;
    endtask

    task automatic vblank_pulse(int n);
        @(negedge clk); vblank = 1'b1;
        repeat (n) @(negedge clk);
        vblank = 1'b0;
    endtask

    initial begin
        logic inv_f [4];
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 768; i++) begin
            @(posedge clk); #1;
            if (i == 767) chk("init_done_at_767", 16'(init_done), 16'd0);
            if (i == 768) chk("init_done_at_768", 16'(init_done), 16'd1);
        end
        rd_check("rd_0_0", 0, 0, 3'd1);
        rd_check("rd_2_2", 2, 2, 3'd1);
        rd_check("rd_1_1", 1, 1, 3'd0);
        rd_check("rd_3_2", 3, 2, 3'd0);
        rd_check("rd_31_23", 31, 23, 3'd1);

        pix_check("pix_tile_1_2", 40, 70, 1'b0, 3'd0);
        pix_check("pix_tile_2_2", 64, 64, 1'b0, 3'd1);
        pix_check("pix_hblank", 64, 64, 1'b1, 3'd0);
        pix_check("pix_h_offscreen", 1030, 64, 1'b0, 3'd0);
        pix_check("pix_v_offscreen", 64, 770, 1'b0, 3'd0);
        pix_check("pix_border", 1000, 740, 1'b0, 3'd1);

        wr(5, 3, 3'd4, 1'b0);
        rd_check("rd_5_3_pending_a", 5, 3, 3'd0);
        rd_check("rd_5_3_pending_b", 5, 3, 3'd0);
        @(negedge clk); vblank = 1'b1;
        @(posedge clk); #1;
        chk("rd_5_3_commit_cycle_old", 16'(rd_tex), 16'd0);
        chk("wr_ready_after_commit", 16'(wr_ready), 16'd1);
        @(posedge clk); #1;
        chk("rd_5_3_after_commit", 16'(rd_tex), 16'd4);
        @(negedge clk); vblank = 1'b0;

        wr(7, 7, 3'd3, 1'b1);
        vblank_pulse(2);
        for (int f = 0; f < 4; f++) begin
            pix_check("pix_flash_tile", 227, 227, 1'b0, 3'd3);
            inv_f[f] = inversion;
            @(negedge clk); hcount = 11'd195;
            @(posedge clk); #1; chk("inv_other_tile", 16'(inversion), 16'd0);
            vblank_pulse(2);
        end
        chk("inv_frame0", 16'(inv_f[0]), 16'd1);
        chk("inv_frame1", 16'(inv_f[1]), 16'd1);
        chk("inv_frame2", 16'(inv_f[2]), 16'd0);
        chk("inv_frame3", 16'(inv_f[3]), 16'd0);
        rd_check("rd_flash_7_7", 7, 7, 3'd3);
        chk("rd_flash_bit_7_7", 16'(rd_flash), 16'd1);

        wr(10, 30, 3'd2, 1'b0);
        vblank_pulse(2);
        rd_check("rd_10_30", 10, 30, 3'd1);
        rd_check("rd_10_23", 10, 23, 3'd1);
        rd_check("rd_10_5", 10, 5, 3'd0);
        for (int i = 0; i < 32; i++) rd_check("row23_scan", i, 23, 3'd1);
        for (int i = 0; i < 24; i++) rd_check("col10_scan", 10, i, (i == 0 || i == 23 || i % 2 == 0) ? 3'd1 : 3'd0);

        pix_check("pix_before_reset", 500, 100, 1'b0, 3'd0);
        rd_check("rd_before_reset", 0, 0, 3'd1);
        wr(9, 9, 3'd5, 1'b0);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("async_hcount_out", 16'(hcount_out), 16'd0);
        chk("async_rd_tex", 16'(rd_tex), 16'd0);
        chk("async_init_done", 16'(init_done), 16'd0);
        chk("async_wr_ready", 16'(wr_ready), 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (770) @(posedge clk);
        #1; chk("reinit_done", 16'(init_done), 16'd1);
        vblank_pulse(2);
        rd_check("rd_9_9_discarded", 9, 9, 3'd0);
        chk("wr_ready_after_reinit", 16'(wr_ready), 16'd1);

        repeat (2) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tile_map_ctl.md
Name: tile_map_ctl

Overview:
- Upstream neighbour of the texture/block generator stage in the background pipeline.
- Owns the 32x24 tile map covering the 1024x768 screen at 32x32 px per tile.
- Each pixel cycle, looks up the tile under hcount/vcount and presents texture_number and inversion, aligned with the registered timing signals.
- Game logic updates tiles through a valid/ready write port (commits deferred to vblank) and reads tiles through a one-cycle read port.

Parameters:
- MAP_W, 32, tiles per row (hcount[9:5] index).
- MAP_H, 24, tiles per column (vcount[9:5] index).
- FLASH_BIT, 4, frame-counter bit that drives flashing (period 2^(FLASH_BIT+1) frames).
- WALL_TEX, 3'd1, texture number written for border and pillar tiles at init.
- FLOOR_TEX, 3'd0, texture number for all other tiles at init.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- hsync, vsync, hblank, vblank  in  1 each  timing inputs
- hcount, vcount  in  11 each  pixel position
- rgb  in  12  pixel colour, passed through
- hsync_out, vsync_out, hblank_out, vblank_out  out  1 each  timing, delayed 1 cycle
- hcount_out, vcount_out  out  11 each  delayed 1 cycle
- rgb_out  out  12  delayed 1 cycle
- texture_number  out  3  tile texture for hcount_out/vcount_out
- inversion  out  1  invert request for the same pixel
- wr_valid  in  1  tile write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_x  in  5  tile column
- wr_y  in  5  tile row
- wr_tex  in  3  new texture number
- wr_flash  in  1  new flash flag
- rd_x, rd_y  in  5 each  tile read address
- rd_tex  out  3  texture of tile (rd_x, rd_y), 1-cycle latency
- rd_flash  out  1  flash flag of the same tile
- init_done  out  1  high once the map is initialised

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Storage: MAP_W*MAP_H entries of 4 bits {flash, tex}.
- Reset (async, any time):
  - All outputs go to 0; init_done=0; wr_ready=0.
  - Pending write is discarded; frame counter is cleared.
  - FSM enters INIT with sweep index 0.
- INIT state:
  - Writes one entry per cycle, index 0..767 (row-major, idx = y*32+x).
  - Entry is {0, WALL_TEX} if x==0, x==31, y==0, y==23, or (x even and y even); otherwise {0, FLOOR_TEX}.
  - After index 767 is written, moves to RUN next cycle and sets init_done=1. INIT takes 768 cycles.
  - While in INIT: texture_number=0, inversion=0, rd_tex=0, rd_flash=0. Timing still passes through.
- RUN state: remains here until reset.
- Pixel path (1-cycle latency):
  - All *_out signals register their inputs every cycle, in every state.
  - texture_number and inversion are registered from the lookup at idx = vcount[9:5]*32 + hcount[9:5].
  - If hcount>=1024, vcount>=768, hblank or vblank: texture_number=0, inversion=0.
  - inversion = entry.flash & frame_cnt[FLASH_BIT].
- Frame counter: width FLASH_BIT+1, increments on the rising edge of vblank (registered previous value), wraps naturally.
- Write port:
  - wr_ready = (state==RUN) && !pend_valid.
  - On handshake, {wr_x, wr_y, wr_tex, wr_flash} are latched into the pending register and pend_valid=1.
  - Commit happens in the first cycle with vblank==1 strictly after the accept cycle. That cycle writes the map and clears pend_valid, so wr_ready rises the next cycle.
  - If wr_x>=32 or wr_y>=24, the commit is dropped (no map change) but pend_valid is still cleared.
  - Visible pixels therefore never see a mid-frame map change.
- Read port:
  - rd_tex/rd_flash are registered from entry (rd_x, rd_y) each cycle.
  - Out-of-range addresses return {0, WALL_TEX} so game logic treats them as solid.
  - A commit and a read of the same tile in the same cycle returns the old value; the new value appears on the following cycle.
- Arithmetic: tile index is 10 bits (y*32 is a shift); no other arithmetic except the frame counter and sweep counter.

Test Plan:
- Reset, run 770 cycles -> init_done rises exactly 768 cycles after reset release; rd (0,0)=1, (2,2)=1, (1,1)=0, (3,2)=0, (31,23)=1.
- Raster sweep with hcount=40, vcount=70 (tile 1,2) -> next cycle texture_number=0, hcount_out=40; hcount=64, vcount=64 (tile 2,2) -> texture_number=1; hblank=1 -> texture_number=0.
- Write (5,3, tex=4, flash=0) mid-frame -> wr_ready drops and tile (5,3) still reads 0 until the first vblank cycle; rd (5,3) returns 4 the cycle after commit; wr_ready returns high.
- Write with flash=1 on tile (7,7), FLASH_BIT=1 -> inversion at that tile toggles every 2 frames; other tiles keep inversion=0.
- Write to (10,30) -> commit dropped; rd (10,30)=1; no tile in row 23 or column 10 changes.
- Assert rst_n low during RUN with a pending write -> outputs 0 immediately; after release, INIT reruns and the pending write is never committed.
